// File: rtl/mem_stage_sram_if.sv
// MEM-stage bus: EXE/MEM register outputs in, MEM/WB register outputs and the ready freeze out.
// master = pipeline side driving the stage, slave = the MEM stage itself.
interface mem_stage_sram_if;
   logic        WB_en_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [31:0] ALU_res_in;
   logic [31:0] val_Rm_in;
   logic [3:0]  dst_in;
   logic        ready;
   logic        WB_en_out;
   logic        mem_read_out;
   logic [31:0] ALU_res_out;
   logic [31:0] mem_data_out;
   logic [3:0]  dst_out;
   logic        addr_err;

   modport master (
      output WB_en_in, mem_read_in, mem_write_in, ALU_res_in, val_Rm_in, dst_in,
      input  ready, WB_en_out, mem_read_out, ALU_res_out, mem_data_out, dst_out, addr_err
   );

   modport slave (
      input  WB_en_in, mem_read_in, mem_write_in, ALU_res_in, val_Rm_in, dst_in,
      output ready, WB_en_out, mem_read_out, ALU_res_out, mem_data_out, dst_out, addr_err
   );
endinterface

// File: rtl/mem_stage_sram.sv
// ARM MEM stage: word data memory with WAIT_CYCLES wait states, ready freeze and MEM/WB register.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range accesses suppress writes, return 0 and raise addr_err.
//
//   state | meaning
//   IDLE  | no access in flight; zero-wait accesses and non-memory ops complete here
//   WAIT  | access pending, cnt counts remaining wait cycles down to 0
//   DONE  | final cycle of an access; write commits / read samples on this edge
module mem_stage_sram #(
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 3
) (
   input logic             clk,
   input logic             rst,
   mem_stage_sram_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic          access;
   logic          ready_c;
   logic          wr_en;
   logic [31:0]   rdata;

   assign access = bus.mem_read_in | bus.mem_write_in;
   // Low index bits only: addresses outside the window alias onto the array.
   assign idx    = AW'((bus.ALU_res_in - 32'(BASE_ADDR)) >> 2);

   always_comb begin
      ready_c = 1'b1;
      case (state)
         IDLE:    ready_c = !(access && (WAIT_CYCLES != 0));
         WAIT:    ready_c = 1'b0;
         default: ready_c = 1'b1;
      endcase
   end

   assign bus.ready = ready_c;

`ifdef MEM_BOUNDS_CHECK_EN
   logic oob;
   assign oob   = access && ((bus.ALU_res_in < 32'(BASE_ADDR)) ||
                             (((bus.ALU_res_in - 32'(BASE_ADDR)) >> 2) >= 32'(DEPTH)));
   assign wr_en = ready_c && !rst && bus.mem_write_in && !oob;
   assign rdata = oob ? 32'h0 : (bus.mem_write_in ? bus.val_Rm_in : mem[idx]);
`else
   assign wr_en = ready_c && !rst && bus.mem_write_in;
   assign rdata = bus.mem_write_in ? bus.val_Rm_in : mem[idx];
   assign bus.addr_err = 1'b0;
`endif

   // Array is deliberately not reset; a reset mid-access simply never reaches the commit edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= bus.val_Rm_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         bus.WB_en_out    <= 1'b0;
         bus.mem_read_out <= 1'b0;
         bus.ALU_res_out  <= 32'h0;
         bus.mem_data_out <= 32'h0;
         bus.dst_out      <= 4'h0;
`ifdef MEM_BOUNDS_CHECK_EN
         bus.addr_err     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (access && (WAIT_CYCLES == 1)) begin
                  state <= DONE;
               end else if (access && (WAIT_CYCLES >= 2)) begin
                  state <= WAIT;
                  cnt   <= CW'(WAIT_CYCLES - 2);
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         // Frozen cycles push a bubble into WB; the data fields keep their last value.
         if (ready_c) begin
            bus.WB_en_out    <= bus.WB_en_in;
            bus.mem_read_out <= bus.mem_read_in;
            bus.ALU_res_out  <= bus.ALU_res_in;
            bus.mem_data_out <= rdata;
            bus.dst_out      <= bus.dst_in;
`ifdef MEM_BOUNDS_CHECK_EN
            bus.addr_err     <= oob;
`endif
         end else begin
            bus.WB_en_out    <= 1'b0;
            bus.mem_read_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: a 3-wait-state and a zero-wait instance against an array/arithmetic model.
// Build with MEM_BOUNDS_CHECK_EN defined to exercise the bounds-checked variant.
module tb_mem_stage_sram;
   localparam int DEPTH = 64;
   localparam int BASE  = 1024;
   localparam int W3    = 3;
`ifdef MEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_stage_sram_if b3 ();
   mem_stage_sram_if b0 ();

   mem_stage_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W3)) dut_w3 (
      .clk(clk), .rst(rst), .bus(b3)
   );
   mem_stage_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst(rst), .bus(b0)
   );

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] mref [2][DEPTH];
   logic [31:0] ealu [2];
   logic [3:0]  edst [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wcyc(input int u);
      return (u == 0) ? W3 : 0;
   endfunction

   task automatic drive(input int u, input bit wb, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
      if (u == 0) begin
         b3.WB_en_in = wb; b3.mem_read_in = rd; b3.mem_write_in = wr;
         b3.ALU_res_in = a; b3.val_Rm_in = v; b3.dst_in = d;
      end else begin
         b0.WB_en_in = wb; b0.mem_read_in = rd; b0.mem_write_in = wr;
         b0.ALU_res_in = a; b0.val_Rm_in = v; b0.dst_in = d;
      end
   endtask

   task automatic sample(input int u, output logic rdy, output logic wbo, output logic rdo,
                         output logic err, output logic [31:0] alu, output logic [31:0] data,
                         output logic [3:0] dst);
      rdy  = (u == 0) ? b3.ready        : b0.ready;
      wbo  = (u == 0) ? b3.WB_en_out    : b0.WB_en_out;
      rdo  = (u == 0) ? b3.mem_read_out : b0.mem_read_out;
      err  = (u == 0) ? b3.addr_err     : b0.addr_err;
      alu  = (u == 0) ? b3.ALU_res_out  : b0.ALU_res_out;
      data = (u == 0) ? b3.mem_data_out : b0.mem_data_out;
      dst  = (u == 0) ? b3.dst_out      : b0.dst_out;
   endtask

   task automatic check_reset_state(input int u);
      logic rdy, wbo, rdo, err; logic [31:0] alu, data; logic [3:0] dst;
      sample(u, rdy, wbo, rdo, err, alu, data, dst);
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_wb", 32'(wbo), 32'd0);
      chk("rst_rd", 32'(rdo), 32'd0);
      chk("rst_alu", alu, 32'h0);
      chk("rst_data", data, 32'h0);
      chk("rst_dst", 32'(dst), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
   endtask

   // One instruction on unit u; the model decides how many frozen cycles precede completion.
   task automatic do_instr(input int u, input bit wb, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] v, input logic [3:0] d,
                           output int lows, output logic [31:0] data_o,
                           output logic wb_o, output logic rd_o, output logic err_o);
      logic rdy, wbo, rdo, err; logic [31:0] alu, data; logic [3:0] dst;
      logic [31:0] off, ed;
      int nl, idx;
      bit oob;
      off = a - 32'(BASE);
      idx = int'((off >> 2) % DEPTH);
      oob = (rd || wr) && ((a < 32'(BASE)) || ((off >> 2) >= 32'(DEPTH)));
      nl  = (rd || wr) ? wcyc(u) : 0;
      drive(u, wb, rd, wr, a, v, d);
      drive(1 - u, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      lows = 0;
      for (int k = 0; k < nl; k++) begin
         sample(u, rdy, wbo, rdo, err, alu, data, dst);
         if (!rdy) lows++;
         chk("ready_wait", 32'(rdy), 32'd0);
         @(posedge clk);
         ealu[1-u] = 32'h0; edst[1-u] = 4'h0;
         @(negedge clk); #1;
         sample(u, rdy, wbo, rdo, err, alu, data, dst);
         chk("bubble_wb", 32'(wbo), 32'd0);
         chk("bubble_rd", 32'(rdo), 32'd0);
         chk("bubble_alu_hold", alu, ealu[u]);
         chk("bubble_dst_hold", 32'(dst), 32'(edst[u]));
      end
      sample(u, rdy, wbo, rdo, err, alu, data, dst);
      if (!rdy) lows++;
      chk("ready_done", 32'(rdy), 32'd1);
      if (BOUNDS && oob) ed = 32'h0;
      else if (wr)       ed = v;
      else               ed = mref[u][idx];
      if (wr && !(BOUNDS && oob)) mref[u][idx] = v;
      @(posedge clk);
      ealu[1-u] = 32'h0; edst[1-u] = 4'h0;
      @(negedge clk); #1;
      sample(u, rdy, wbo, rdo, err, alu, data, dst);
      chk("wb_out", 32'(wbo), 32'(wb));
      chk("rd_out", 32'(rdo), 32'(rd));
      chk("alu_out", alu, a);
      chk("dst_out", 32'(dst), 32'(d));
      if (rd) chk("load_data", data, ed);
      chk("addr_err", 32'(err), 32'(BOUNDS && oob));
      ealu[u] = a; edst[u] = d;
      lows = lows; data_o = data; wb_o = wbo; rd_o = rdo; err_o = err;
   endtask

   initial begin
      int lows;
      logic [31:0] dout;
      logic wbo, rdo, err;
      for (int u = 0; u < 2; u++) begin
         ealu[u] = 32'h0; edst[u] = 4'h0;
      end
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1 rst = 1'b1;
      #2;
      check_reset_state(0);
      check_reset_state(1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;

      // Known contents everywhere so every later load has a defined expectation.
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < DEPTH; i++)
            do_instr(u, 1'b0, 1'b0, 1'b1, 32'(BASE + 4 * i), $urandom, 4'h0, lows, dout, wbo, rdo, err);

      // Pass-through of a non-memory op.
      do_instr(0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3, lows, dout, wbo, rdo, err);
      chk("t2_lows", 32'(lows), 32'd0);
      chk("t2_wb", 32'(wbo), 32'd1);

      // Three wait states on store and load.
      do_instr(0, 1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0, lows, dout, wbo, rdo, err);
      chk("t3_str_lows", 32'(lows), 32'd3);
      do_instr(0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7, lows, dout, wbo, rdo, err);
      chk("t3_ldr_lows", 32'(lows), 32'd3);
      chk("t3_ldr_data", dout, 32'hDEADBEEF);
      chk("t3_ldr_rd", 32'(rdo), 32'd1);
      chk("t3_ldr_wb", 32'(wbo), 32'd1);

      // Zero-wait memory, back-to-back store then load.
      do_instr(1, 1'b0, 1'b0, 1'b1, 32'd1024, 32'h1234, 4'd0, lows, dout, wbo, rdo, err);
      chk("t4_str_lows", 32'(lows), 32'd0);
      do_instr(1, 1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd2, lows, dout, wbo, rdo, err);
      chk("t4_ldr_lows", 32'(lows), 32'd0);
      chk("t4_ldr_data", dout, 32'h1234);

      // Both read and write set: store wins and the stored value is returned.
      do_instr(0, 1'b1, 1'b1, 1'b1, 32'd1040, 32'h0BADF00D, 4'd5, lows, dout, wbo, rdo, err);
      chk("both_data", dout, 32'h0BADF00D);

      // Just past the window: alias of word 0, or flagged when bounds-checked.
      do_instr(0, 1'b0, 1'b0, 1'b1, 32'd1024, 32'hCAFE0000, 4'd0, lows, dout, wbo, rdo, err);
      do_instr(0, 1'b1, 1'b1, 1'b0, 32'(BASE + 4 * DEPTH), 32'h0, 4'd1, lows, dout, wbo, rdo, err);
      chk("t6_data", dout, BOUNDS ? 32'h0 : 32'hCAFE0000);
      chk("t6_err", 32'(err), 32'(BOUNDS));

      for (int n = 0; n < 400; n++) begin
         int u, r;
         bit rd, wr;
         logic [31:0] a;
         u  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         if (r < 8)       a = 32'(BASE + 4 * int'($urandom_range(0, DEPTH - 1)) + int'($urandom_range(0, 3)));
         else if (r == 8) a = 32'(BASE + 4 * DEPTH + 4 * int'($urandom_range(0, 3 * DEPTH)));
         else             a = 32'($urandom_range(0, BASE - 1));
         do_instr(u, 1'($urandom_range(0, 1)), rd, wr, a, $urandom, 4'($urandom_range(0, 15)),
                  lows, dout, wbo, rdo, err);
      end

      // Reset while a store is waiting: the store is dropped.
      do_instr(0, 1'b0, 1'b0, 1'b1, 32'd1028, 32'hAAAA, 4'd0, lows, dout, wbo, rdo, err);
      drive(0, 1'b0, 1'b0, 1'b1, 32'd1028, 32'hBBBB, 4'd0);
      #1;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      check_reset_state(0);
      check_reset_state(1);
      for (int u = 0; u < 2; u++) begin
         ealu[u] = 32'h0; edst[u] = 4'h0;
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      do_instr(0, 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd4, lows, dout, wbo, rdo, err);
      chk("t5_lows", 32'(lows), 32'd3);
      chk("t5_data", dout, 32'hAAAA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
